display_scheduler: RTL



---
 rtl/display_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/display_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/display_sched_pkg.sv
// display_sched_pkg
// Shared types and helpers for the display scheduler.
//   state_t  : scheduler FSM state encoding (IDLE, SHOW, GAP)
//   dwell_w  : width of the dwell counter for a given DWELL
// Optional feature macro used by the scheduler: DISPLAY_SCHED_PREEMPT_EN.
package display_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Counter must hold 0..dwell-1; never narrower than one bit.
    function automatic int dwell_w(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter with an optional urgent override.
// Ports:
//   req    in  NREQ : request lines
//   ptr    in  PW   : index of the last winner; search starts at ptr+1
//   urgent in  NREQ : urgent mask (already qualified by req); lowest index
//                     urgent requester beats the round-robin order
//   onehot out NREQ : one-hot winner, zero when no request
//   idx    out PW   : winner index (0 when no request)
//   any    out 1    : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] urgent,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic found;
    logic found_urg;
    int   cand;

    always_comb begin
        idx       = '0;
        found     = 1'b0;
        found_urg = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = PW'(cand);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found_urg && urgent[i]) begin
                found_urg = 1'b1;
                idx       = PW'(i);
            end
        end
        any    = |req;
        onehot = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler
// Time-shares the 7-segment display between NREQ requesters. Grants the
// display round-robin for DWELL refresh cycles, then forces one blank GAP
// cycle before re-arbitrating.
// Ports:
//   clk    in  1         : refresh clock
//   rst    in  1         : synchronous active-high reset
//   req    in  NREQ      : level-sensitive display requests
//   urgent in  NREQ      : preemption requests (used only with the macro)
//   val    in  NREQ*VALW : flattened requester values, i at [i*VALW +: VALW]
//   T      out VALW      : value to the display driver (registered)
//   blank  out 1         : display shows nothing
//   grant  out NREQ      : one-hot current owner, zero when none
//   ack    out NREQ      : one-cycle pulse on the last cycle of a full dwell
// Macro DISPLAY_SCHED_PREEMPT_EN: when defined, an urgent non-owner ends the
// current slot early (no ack) and urgent requesters win arbitration.
//
// state | meaning
// IDLE  | no owner, display blank, waiting for any req
// SHOW  | owner holds the display, dwell counter running
// GAP   | one blank cycle between slots, then re-arbitrate
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 1000,
    parameter int VALW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      urgent,
    input  logic [NREQ*VALW-1:0] val,
    output logic [VALW-1:0]      T,
    output logic                 blank,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = dwell_w(DWELL);
    localparam logic [CW-1:0] LAST     = CW'(DWELL - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DWELL - 2);

    state_t          state, state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic            do_grant;
    logic            do_ack;
    logic            preempt;
    logic [NREQ-1:0] urg_mask;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_any;
    logic [VALW-1:0] val_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_val
        assign val_arr[i] = val[i*VALW +: VALW];
    end

`ifdef DISPLAY_SCHED_PREEMPT_EN
    assign urg_mask = urgent & req;
    assign preempt  = (|(urg_mask & ~grant)) && !urgent[owner];
`else
    logic unused_urgent;
    assign unused_urgent = ^urgent;
    assign urg_mask      = '0;
    assign preempt       = 1'b0;
`endif

    rr_arbiter #(
        .NREQ(NREQ),
        .PW  (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .urgent(urg_mask),
        .onehot(win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        do_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nx = SHOW;
                    do_grant = 1'b1;
                end
            end
            SHOW: begin
                if (!req[owner] || preempt || cnt == LAST) begin
                    state_nx = GAP;
                end else if (cnt == PRE_LAST) begin
                    // ack is registered, so it is launched one cycle early
                    // to land on the final SHOW cycle.
                    do_ack = 1'b1;
                end
            end
            GAP: begin
                if (win_any) begin
                    state_nx = SHOW;
                    do_grant = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            owner <= '0;
            cnt   <= '0;
            T     <= '0;
            blank <= 1'b1;
            grant <= '0;
            ack   <= '0;
        end else begin
            state <= state_nx;
            ack   <= '0;
            if (do_grant) begin
                owner <= win_idx;
                ptr   <= win_idx;
                grant <= win_oh;
                blank <= 1'b0;
                T     <= val_arr[win_idx];
                cnt   <= '0;
            end else if (state_nx == SHOW) begin
                T <= val_arr[owner];
                if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                end
                if (do_ack) begin
                    ack <= grant;
                end
            end else begin
                // GAP/IDLE: T keeps the last shown value.
                grant <= '0;
                blank <= 1'b1;
            end
        end
    end

endmodule
